// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: generates the PC, issues single-outstanding reads on
// an SRAM-like instruction port and holds one fetched instruction for decode.
// Branch redirects from decode retarget fetch and cancel wrong-path reads.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_collect,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {S_INIT, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic        cancel_q, cancel_d;
  logic [31:0] fs_inst_q, fs_inst_d;
  logic [31:0] fs_pc_q, fs_pc_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        slot_free;
  logic        addr_hs;

  assign br_taken  = br_collect[32];
  assign br_target = br_collect[31:0];

  // The slot can take a new instruction if it is empty or being drained now.
  assign slot_free = ~fs_valid_q | ds_allowin;

  assign inst_sram_req  = (state_q == S_REQ) & slot_free;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  // A redirect retargets a not-yet-accepted request in the same cycle.
  assign inst_sram_addr = br_taken ? br_target : req_pc_q;
  assign addr_hs        = inst_sram_req & inst_sram_addr_ok;

  assign fs_to_ds_valid = fs_valid_q;
  assign fs_to_ds_bus   = {fs_inst_q, fs_pc_q};

  // Next-state logic for the fetch FSM, PC tracking and the instruction slot.
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    pending_pc_d = pending_pc_q;
    fs_valid_d   = fs_valid_q;
    cancel_d     = cancel_q;
    fs_inst_d    = fs_inst_q;
    fs_pc_d      = fs_pc_q;

    if (fs_valid_q && ds_allowin) begin
      fs_valid_d = 1'b0;
    end

    case (state_q)
      S_INIT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (addr_hs) begin
          // The accepted address already reflects any same-cycle redirect,
          // so the next sequential PC follows whatever was actually issued.
          state_d      = S_WAIT;
          pending_pc_d = inst_sram_addr;
          req_pc_d     = inst_sram_addr + 32'd4;
        end else if (br_taken) begin
          req_pc_d = br_target;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
          if (!cancel_q && !br_taken) begin
            fs_inst_d  = inst_sram_rdata;
            fs_pc_d    = pending_pc_q;
            fs_valid_d = 1'b1;
          end
        end else if (br_taken) begin
          // The outstanding read is wrong-path; drop it when it returns.
          cancel_d = 1'b1;
        end
        if (br_taken) begin
          req_pc_d = br_target;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // A redirect flushes the held instruction, overriding any refill.
    if (br_taken && (state_q != S_INIT)) begin
      fs_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      req_pc_q     <= RESET_PC;
      pending_pc_q <= RESET_PC;
      fs_valid_q   <= 1'b0;
      cancel_q     <= 1'b0;
      fs_inst_q    <= 32'd0;
      fs_pc_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      pending_pc_q <= pending_pc_d;
      fs_valid_q   <= fs_valid_d;
      cancel_q     <= cancel_d;
      fs_inst_q    <= fs_inst_d;
      fs_pc_q      <= fs_pc_d;
    end
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline; sits in front of the decode stage.
- Generates the PC and issues single-outstanding read requests on an SRAM-like instruction port (req/addr_ok/data_ok).
- Holds one fetched instruction and presents it to decode as {inst, pc}.
- Consumes decode's branch-redirect bus {br_taken, br_target} to redirect fetch and cancel wrong-path work.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetch after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
ds_allowin  in  1  decode can accept an instruction this cycle
br_collect  in  33  {br_taken, br_target[31:0]}; br_taken is a one-cycle pulse from a valid branch in decode
fs_to_ds_valid  out  1  fetch slot holds a valid instruction
fs_to_ds_bus  out  64  {fs_inst[31:0], fs_pc[31:0]}
inst_sram_req  out  1  read request
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10 (word)
inst_sram_addr  out  32  request address
inst_sram_addr_ok  in  1  request accepted this cycle (req & addr_ok)
inst_sram_data_ok  in  1  read data valid this cycle
inst_sram_rdata  in  32  read data

Behaviour:
- Reset: async clear.
  - state=INIT, req_pc=RESET_PC, fs_valid=0, cancel=0, fs_inst=0, fs_pc=0.
  - Outputs: inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_bus=0.
- Reset mid-operation: an outstanding transaction is abandoned. After release, fetch restarts from RESET_PC. Any data_ok arriving in INIT is ignored.
- FSM states: INIT, REQ, WAIT.
  - INIT: req=0; next state is REQ unconditionally (one cycle after reset release).
  - REQ: inst_sram_req = slot_free, where slot_free = ~fs_valid | ds_allowin; inst_sram_addr = req_pc. On req & addr_ok: state becomes WAIT.
  - WAIT: req=0, one outstanding read. On data_ok: state becomes REQ.
    - cancel=1: data dropped, cancel cleared.
    - cancel=0: fs_inst <= rdata, fs_pc <= pending_pc, fs_valid <= 1.
- Address before acceptance: may change while req is high but addr_ok is low (redirect only). Once addr_ok is seen, pending_pc <= inst_sram_addr.
- Sequential PC: on an accepted request with no redirect in the same cycle, req_pc <= req_pc + 4 (32-bit wrap, no overflow check).
- Redirect on br_taken=1 (any state except INIT):
  - req_pc <= br_target.
  - fs_valid <= 0; the held instruction is on the wrong path. This takes priority over a handshake in the same cycle.
  - In REQ with addr_ok=0: the request is retargeted. inst_sram_addr shows br_target combinationally that cycle: inst_sram_addr = br_taken ? br_target : req_pc.
  - In REQ with addr_ok=1 the same cycle: the combinational address is the target, so the accepted request is correct. cancel stays 0 and req_pc <= br_target + 4.
  - In WAIT without data_ok: cancel <= 1.
  - In WAIT with data_ok the same cycle: data dropped, fs_valid stays 0.
  - Redirect while cancel is already 1: cancel stays 1 and req_pc takes the newest target.
- Decode handshake:
  - fs_to_ds_valid = fs_valid.
  - fs_valid clears on fs_to_ds_valid & ds_allowin unless refilled in the same cycle.
  - A refill and a drain in the same cycle are impossible: one outstanding read, and a request issues only when the slot is free.
- Single outstanding: no new request while in WAIT, so data_ok always matches pending_pc.
- Low address bits: br_target[1:0] passed unmodified. Alignment exceptions are out of scope.
- Latency: best case (addr_ok immediate, data_ok next cycle) gives one instruction every 2 cycles. First req is asserted 1 cycle after reset release.

Test Plan:
- Reset release, addr_ok=1 always, data_ok one cycle after acceptance -> req high at cycle 1 with addr 0x1c000000; fs_to_ds_bus pcs 0x1c000000, 0x1c000004, 0x1c000008 on successive valid cycles.
- ds_allowin held 0 for 5 cycles with fs_valid=1 -> req stays 0, bus stable with pc 0x1c000004. After ds_allowin rises -> req issues that cycle for 0x1c000008.
- br_taken with target 0x1c000100 while in WAIT for 0x1c000010 -> that data_ok is dropped (fs_valid stays 0); next request addr 0x1c000100 and delivered pc 0x1c000100.
- br_taken with target 0x1c000200 in the same cycle as addr_ok in REQ -> inst_sram_addr=0x1c000200, cancel stays 0; delivered pc 0x1c000200, next request 0x1c000204.
- addr_ok held low 3 cycles, br_taken (target 0x1c000300) in cycle 2 -> addr changes from old pc to 0x1c000300 before acceptance; fs_valid cleared.
- Assert reset during WAIT, then data_ok during reset and INIT -> no fs_valid. After release, first request is 0x1c000000.
